instr_fetch_seq: RTL and testbench
==================================

Name: instr_fetch_seq

Overview:
- Program sequencer that sits upstream of the 9-bit `proc` datapath and replaces the free-running address counter.
- Reads instruction words from the synchronous single-port program ROM and presents them on DIN.
- Pulses Run for exactly one cycle per instruction, then waits for Done before fetching the next word.
- For mvi it delivers the immediate word on DIN in the cycle after the instruction is loaded.

Parameters:
- AW, 5, ROM address width; PC wraps modulo 2^AW.
- LAST_ADDR, 31, address of the final program word; ending is checked after each instruction completes.
- LOOP, 1, 1 = restart at PC 0 after LAST_ADDR; 0 = enter HALTED.
- TIMEOUT, 15, maximum EXEC cycles to wait for Done before flagging Error.

Ports:
- Clock  in  1  system clock, rising edge.
- Reset  in  1  synchronous, active-high reset.
- Enable  in  1  permits instruction issue; level-sensitive.
- StepMode  in  1  1 = one instruction per Step pulse.
- Step  in  1  single-cycle, already-synchronised step request.
- RomAddr  out  AW  ROM address; ROM q is valid one cycle later.
- RomQ  in  9  ROM data output.
- DIN  out  9  registered word to proc DIN.
- Run  out  1  one-cycle issue strobe to proc.
- Done  in  1  proc completion strobe.
- PC  out  AW  address of the current or next instruction.
- Busy  out  1  high in FETCH, LOAD, ISSUE and EXEC.
- Halted  out  1  high in HALTED.
- Error  out  1  sticky watchdog flag; cleared only by Reset.

Behaviour:
- Reset, synchronous and active-high, gives: state IDLE, PC=0, RomAddr=0, DIN=0, Run=0, Busy=0, Halted=0, Error=0, watchdog=0. Reset overrides every state, including mid-EXEC.
- Opcode is DIN[8:6]; mvi = 3'b001.
- RomAddr is combinational from state: PC in FETCH; PC+1 (mod 2^AW) in LOAD when RomQ[8:6]==mvi; otherwise PC.
- IDLE:
  - Go to FETCH when Enable && (!StepMode || Step).
  - A Step pulse while Enable=0 is ignored, not remembered.
- FETCH: RomAddr=PC; always go to LOAD.
- LOAD: DIN<=RomQ; go to ISSUE.
- ISSUE: Run=1 for this cycle only; proc loads IR on this edge.
  - If DIN is mvi: DIN<=RomQ (immediate) on this edge, so the immediate is stable in proc's T1 cycle; PC<=PC+2.
  - Otherwise PC<=PC+1.
  - All PC arithmetic is AW bits and wraps silently; an mvi at 2^AW-1 takes its immediate from address 0.
  - Go to EXEC with watchdog=0.
- EXEC:
  - Done is sampled only in EXEC; Done in any other state is ignored.
  - On Done, the next state depends on the completed instruction:
    - It occupied LAST_ADDR (at PC, or at PC+1 for mvi) and LOOP=0: go to HALTED.
    - It occupied LAST_ADDR and LOOP=1: PC<=0, then apply the continue rule below.
    - Continue rule: if StepMode || !Enable go to IDLE, else go to FETCH. Fetch latency is 3 cycles from Done to the next Run.
  - Otherwise watchdog increments each cycle. When watchdog reaches TIMEOUT without Done: Error<=1, go to HALTED.
  - Done and the timeout in the same cycle: Done wins.
- Enable falling mid-instruction: the current instruction completes through Done, then the block goes to IDLE. Run is never issued with Enable=0 sampled in IDLE.
- HALTED: Run=0, DIN holds its last value; leave only by Reset.
- Run is never high in two consecutive cycles. There is at most one Run per Done.

Decomposition:
- Shared package `seq_pkg`:
  - State enum {IDLE, FETCH, LOAD, ISSUE, EXEC, HALTED}.
  - Constant OP_MVI=3'b001.
  - Constant WORD_W=9.
- One natural sub-module: `done_watchdog`, a TIMEOUT-bounded counter with clear/enable/expired. Everything else stays in the single FSM.

Test Plan:
- ROM[0]=mv R0,R1 (9'o001… non-mvi), proc model asserts Done 2 cycles after Run → Run at cycle 3 after Reset release, DIN=ROM[0], next Run 3 cycles after Done, PC=1.
- ROM[4]=mvi R2 (9'b001_010_000), ROM[5]=9'd200 → DIN=ROM[4] in the Run cycle, DIN=200 the following cycle, PC becomes 6, ROM[5] is never issued as an instruction.
- StepMode=1, three Step pulses spaced 20 cycles apart → exactly three Run pulses, Busy low between them, PC advances 0→1→2→3.
- LAST_ADDR=3, LOOP=0, and a separate run with mvi at 31 with AW=5, LOOP=1 → Halted=1 after the instruction at 3; the second run fetches its immediate from address 0 and PC wraps to 1.
- Done withheld for TIMEOUT=15 cycles → Error=1 and Halted=1 on the 15th EXEC cycle; Done at exactly cycle 15 → no Error.
- Reset asserted for one cycle mid-EXEC, and Enable dropped mid-EXEC → after Reset: IDLE, PC=0, DIN=0, Error=0; after Enable drop: Done is accepted, then IDLE, no further Run.

Source files
------------

// File: rtl/seq_pkg.sv
// Shared types and constants for the program sequencer in front of the 9-bit proc datapath.
package seq_pkg;

    localparam int WORD_W = 9;
    localparam logic [2:0] OP_MVI = 3'b001;

    typedef enum logic [2:0] {IDLE, FETCH, LOAD, ISSUE, EXEC, HALTED} state_t;

    function automatic logic is_mvi(input logic [WORD_W-1:0] word);
        return word[WORD_W-1 -: 3] == OP_MVI;
    endfunction

endpackage

// File: rtl/done_watchdog.sv
// Counts cycles spent waiting for Done; expired is high on the last permitted cycle.
module done_watchdog #(
    parameter int TIMEOUT = 15
) (
    input  logic clk,
    input  logic rst,
    input  logic clear,
    input  logic enable,
    output logic expired
);

    localparam int CW = $clog2(TIMEOUT + 1);

    logic [CW-1:0] count;

    always_ff @(posedge clk) begin
        if (rst || clear)
            count <= '0;
        else if (enable && count != CW'(TIMEOUT))
            count <= count + 1'b1;
    end

    // count holds completed wait cycles, so the TIMEOUT-th cycle sees TIMEOUT-1
    assign expired = enable && (count == CW'(TIMEOUT - 1));

endmodule

// File: rtl/instr_fetch_seq.sv
// Program sequencer: fetches words from a synchronous ROM, issues one Run per
// instruction, feeds the mvi immediate one cycle later and waits for Done.
module instr_fetch_seq
    import seq_pkg::*;
#(
    parameter int AW        = 5,
    parameter int LAST_ADDR = 31,
    parameter int LOOP      = 1,
    parameter int TIMEOUT   = 15
) (
    input  logic              Clock,
    input  logic              Reset,
    input  logic              Enable,
    input  logic              StepMode,
    input  logic              Step,
    output logic [AW-1:0]     RomAddr,
    input  logic [WORD_W-1:0] RomQ,
    output logic [WORD_W-1:0] DIN,
    output logic              Run,
    input  logic              Done,
    output logic [AW-1:0]     PC,
    output logic              Busy,
    output logic              Halted,
    output logic              Error
);

    state_t        state, next_state;
    logic [AW-1:0] instr_addr;
    logic          instr_mvi;
    logic          last_instr;
    logic          wd_expired;

    done_watchdog #(.TIMEOUT(TIMEOUT)) u_wd (
        .clk     (Clock),
        .rst     (Reset),
        .clear   (state == ISSUE),
        .enable  (state == EXEC),
        .expired (wd_expired)
    );

    // An mvi also owns the word after it, so it can be the one covering LAST_ADDR
    assign last_instr = (instr_addr == AW'(LAST_ADDR)) ||
                        (instr_mvi && AW'(instr_addr + 1'b1) == AW'(LAST_ADDR));

    always_ff @(posedge Clock) begin
        if (Reset)
            state <= IDLE;
        else
            state <= next_state;
    end

    always_comb begin
        next_state = state;
        case (state)
            IDLE:   if (Enable && (!StepMode || Step)) next_state = FETCH;
            FETCH:  next_state = LOAD;
            LOAD:   next_state = ISSUE;
            ISSUE:  next_state = EXEC;
            EXEC: begin
                if (Done) begin
                    if (last_instr && LOOP == 0)
                        next_state = HALTED;
                    else if (StepMode || !Enable)
                        next_state = IDLE;
                    else
                        next_state = FETCH;
                end else if (wd_expired) begin
                    next_state = HALTED;
                end
            end
            HALTED: next_state = HALTED;
            default: next_state = IDLE;
        endcase
    end

    always_comb begin
        Run     = (state == ISSUE);
        Busy    = state inside {FETCH, LOAD, ISSUE, EXEC};
        Halted  = (state == HALTED);
        RomAddr = PC;
        // Look ahead to the immediate so it arrives in time for ISSUE
        if (state == LOAD && is_mvi(RomQ))
            RomAddr = PC + 1'b1;
    end

    always_ff @(posedge Clock) begin
        if (Reset) begin
            PC         <= '0;
            DIN        <= '0;
            Error      <= 1'b0;
            instr_addr <= '0;
            instr_mvi  <= 1'b0;
        end else begin
            case (state)
                LOAD: DIN <= RomQ;
                ISSUE: begin
                    instr_addr <= PC;
                    instr_mvi  <= is_mvi(DIN);
                    if (is_mvi(DIN)) begin
                        DIN <= RomQ;
                        PC  <= PC + 2'd2;
                    end else begin
                        PC  <= PC + 1'b1;
                    end
                end
                EXEC: begin
                    if (Done) begin
                        if (last_instr && LOOP != 0)
                            PC <= '0;
                    end else if (wd_expired) begin
                        Error <= 1'b1;
                    end
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_instr_fetch_seq.sv
// Bench for instr_fetch_seq: ROM + proc models around a looping instance and a
// halting instance (LAST_ADDR=3, LOOP=0), checked against a program-order model.
module tb_instr_fetch_seq;

    localparam int LAST_A = 31;

    logic       clk = 1'b0, rst = 1'b1, en = 1'b0, stepm = 1'b0, step = 1'b0;
    logic       done_a = 1'b0, done_b = 1'b0;
    logic [4:0] raddr_a, pc_a, raddr_b, pc_b;
    logic [8:0] romq_a, din_a, romq_b, din_b;
    logic       run_a, busy_a, halted_a, err_a;
    logic       run_b, busy_b, halted_b, err_b;
    logic [8:0] rom [32];
    int         total = 0, bad = 0, m_pc = 0, cnt_b = 0, nb = 0;

    instr_fetch_seq u_dut (
        .Clock(clk), .Reset(rst), .Enable(en), .StepMode(stepm), .Step(step),
        .RomAddr(raddr_a), .RomQ(romq_a), .DIN(din_a), .Run(run_a), .Done(done_a),
        .PC(pc_a), .Busy(busy_a), .Halted(halted_a), .Error(err_a)
    );

    instr_fetch_seq #(.LAST_ADDR(3), .LOOP(0)) u_halt (
        .Clock(clk), .Reset(rst), .Enable(en), .StepMode(stepm), .Step(step),
        .RomAddr(raddr_b), .RomQ(romq_b), .DIN(din_b), .Run(run_b), .Done(done_b),
        .PC(pc_b), .Busy(busy_b), .Halted(halted_b), .Error(err_b)
    );

    always #5 clk = ~clk;

    always @(posedge clk) begin
        romq_a <= rom[raddr_a];
        romq_b <= rom[raddr_b];
    end

    // proc model for the halting instance: Done two cycles after each Run
    always @(negedge clk) begin
        if (rst) begin
            cnt_b  = 0;
            done_b = 1'b0;
        end else if (run_b) begin
            cnt_b  = 2;
            done_b = 1'b0;
        end else if (cnt_b > 0) begin
            cnt_b--;
            done_b = (cnt_b == 0);
        end else begin
            done_b = 1'b0;
        end
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    // exp_n < 0: expect no Run within limit cycles; else Run exactly exp_n cycles on
    task automatic wait_run(input int exp_n, input int limit, input string tag);
        int n = 0;
        bit found = 0;
        while (!found && n < limit) begin
            @(negedge clk);
            done_a = 1'b0;
            step   = 1'b0;
            n++;
            if (run_a) found = 1;
        end
        if (exp_n < 0) chk(tag, 32'(found), 32'd0);
        else           chk(tag, found ? 32'(n) : 32'd999, 32'(exp_n));
    endtask

    // Called in the Run cycle; returns in the cycle where Done is driven high
    task automatic run_one(input int d, input bit drop_en, input string tag);
        logic [8:0] w, imm;
        bit mvi, last;
        int nxt;
        w    = rom[m_pc];
        imm  = rom[(m_pc + 1) % 32];
        mvi  = (w[8:6] == 3'b001);
        nxt  = (m_pc + (mvi ? 2 : 1)) % 32;
        last = (m_pc == LAST_A) || (mvi && ((m_pc + 1) % 32) == LAST_A);
        chk({tag, " din"}, 32'(din_a), 32'(w));
        chk({tag, " pc"}, 32'(pc_a), 32'(m_pc));
        chk({tag, " busy"}, 32'(busy_a), 32'd1);
        for (int i = 1; i <= d; i++) begin
            @(negedge clk);
            if (i == 1) begin
                chk({tag, " run_once"}, 32'(run_a), 32'd0);
                chk({tag, " din_next"}, 32'(din_a), 32'(mvi ? imm : w));
                chk({tag, " pc_next"}, 32'(pc_a), 32'(nxt));
                if (drop_en) en = 1'b0;
            end
            if (i == d) done_a = 1'b1;
        end
        m_pc = last ? 0 : nxt;
    endtask

    task automatic rand_rom();
        for (int i = 0; i < 32; i++) begin
            rom[i] = 9'($urandom_range(0, 511));
            if ($urandom_range(0, 3) == 0) rom[i][8:6] = 3'b001;
        end
    endtask

    initial begin
        for (int i = 0; i < 32; i++) rom[i] = 9'(8 + i);
        rom[0]  = 9'o001;
        rom[4]  = 9'b001_010_000;
        rom[5]  = 9'd200;
        rom[31] = 9'b001_000_000;
        rst = 1'b1; en = 1'b1; stepm = 1'b0;
        repeat (3) @(negedge clk);
        chk("rst pc", 32'(pc_a), 32'd0);
        chk("rst romaddr", 32'(raddr_a), 32'd0);
        chk("rst din", 32'(din_a), 32'd0);
        chk("rst run", 32'(run_a), 32'd0);
        chk("rst busy", 32'(busy_a), 32'd0);
        chk("rst halted", 32'(halted_a), 32'd0);
        chk("rst error", 32'(err_a), 32'd0);
        chk("rst halted_b", 32'(halted_b), 32'd0);

        // Directed program: mvi at 4 (imm 200) and at 31 (imm from address 0)
        rst = 1'b0; m_pc = 0;
        wait_run(3, 10, "first_run");
        for (int k = 0; k < 33; k++) begin
            run_one(2, 1'b0, "seq");
            wait_run(3, 10, "seq_lat");
        end

        // Done on the final watchdog cycle still wins
        run_one(15, 1'b0, "d15");
        wait_run(3, 10, "d15_lat");
        chk("d15 error", 32'(err_a), 32'd0);
        run_one(1, 1'b0, "d1");
        wait_run(3, 10, "d1_lat");

        for (int k = 0; k < 30; k++) begin
            run_one($urandom_range(1, 8), 1'b0, "rnd");
            if (k % 10 == 0) rand_rom();
            wait_run(3, 10, "rnd_lat");
        end

        // Enable drops during EXEC: instruction finishes, then idle
        run_one(4, 1'b1, "en_drop");
        wait_run(-1, 20, "en_drop_no_run");
        chk("en_drop busy", 32'(busy_a), 32'd0);
        chk("en_drop halted", 32'(halted_a), 32'd0);
        chk("en_drop pc", 32'(pc_a), 32'(m_pc));

        // Step mode from a fresh reset
        rst = 1'b1; en = 1'b1; stepm = 1'b1;
        for (int i = 0; i < 4; i++) rom[i] = 9'(16 + i);
        repeat (2) @(negedge clk);
        rst = 1'b0; m_pc = 0;
        wait_run(-1, 8, "step_idle");
        for (int k = 0; k < 3; k++) begin
            step = 1'b1;
            wait_run(3, 6, "step_lat");
            run_one(2, 1'b0, "step");
            wait_run(-1, 17, "step_gap");
            chk("step busy", 32'(busy_a), 32'd0);
            chk("step pc", 32'(pc_a), 32'(k + 1));
        end
        en = 1'b0; step = 1'b1;
        wait_run(-1, 3, "step_disabled");
        en = 1'b1;
        wait_run(-1, 10, "step_not_remembered");

        // Reset for one cycle in the middle of EXEC
        stepm = 1'b0;
        wait_run(3, 6, "resume");
        chk("resume pc", 32'(pc_a), 32'(m_pc));
        @(negedge clk); @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0; en = 1'b0;
        chk("midrst pc", 32'(pc_a), 32'd0);
        chk("midrst din", 32'(din_a), 32'd0);
        chk("midrst error", 32'(err_a), 32'd0);
        chk("midrst busy", 32'(busy_a), 32'd0);
        chk("midrst run", 32'(run_a), 32'd0);
        wait_run(-1, 6, "midrst_idle");

        // Watchdog: Done withheld
        en = 1'b1;
        wait_run(3, 6, "to_run");
        chk("to pc", 32'(pc_a), 32'd0);
        for (int k = 1; k <= 16; k++) begin
            @(negedge clk);
            if (k == 15) begin
                chk("to c15 halted", 32'(halted_a), 32'd0);
                chk("to c15 error", 32'(err_a), 32'd0);
            end
            if (k == 16) begin
                chk("to halted", 32'(halted_a), 32'd1);
                chk("to error", 32'(err_a), 32'd1);
                chk("to busy", 32'(busy_a), 32'd0);
            end
        end
        done_a = 1'b1;
        wait_run(-1, 10, "halted_no_run");
        chk("halted stays", 32'(halted_a), 32'd1);
        chk("error sticky", 32'(err_a), 32'd1);

        // Halting instance: four instructions then HALTED at PC 4
        rst = 1'b1;
        repeat (2) @(negedge clk);
        chk("rst clears error", 32'(err_a), 32'd0);
        chk("rst clears halted", 32'(halted_a), 32'd0);
        rst = 1'b0; nb = 0;
        for (int k = 0; k < 60; k++) begin
            @(negedge clk);
            done_a = 1'b0;
            if (run_b) nb++;
        end
        chk("halt runs", 32'(nb), 32'd4);
        chk("halt halted", 32'(halted_b), 32'd1);
        chk("halt pc", 32'(pc_b), 32'd4);
        chk("halt error", 32'(err_b), 32'd0);
        chk("halt busy", 32'(busy_b), 32'd0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
